counter_channel: RTL and testbench



---
 rtl/counter_channel.sv | 125 ++++++++++++
 tb/tb_counter_channel.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_channel.sv
// counter_channel: one 8254-style programmable interval counter channel
// (modes 0-5, gate edge/level handling, count latch and status readback).
module counter_channel #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             GATE,
    input  logic             cw_wr,
    input  logic [2:0]       cw_mode,
    input  logic             count_wr,
    input  logic [WIDTH-1:0] count_data,
    input  logic             latch_cmd,
    input  logic             read_ack,
    output logic             OUT,
    output logic             null_count,
    output logic [WIDTH-1:0] count_out,
    output logic             latched,
    output logic [4:0]       status
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    logic [2:0]       mode;
    logic [WIDTH-1:0] cr, ce, latch_val;
    logic             cr_valid, running, armed, trig_q, prev_gate;

    logic [2:0]       cw_alias;
    logic [WIDTH:0]   n_full;
    logic [WIDTH-1:0] n2, hi, lo, ld_val;
    logic             slow, trigger, load, en, tc;

    assign cw_alias = (cw_mode[2:1] == 2'b11) ? {1'b0, cw_mode[1:0]} : cw_mode;
    // Modes 2/3 see the count as 1..2^WIDTH with 1 promoted to 2.
    assign n_full   = (cr == '0) ? {1'b1, {WIDTH{1'b0}}} :
                      (cr == ONE) ? (WIDTH+1)'(2) : {1'b0, cr};
    assign n2       = n_full[WIDTH-1:0];
    assign hi       = WIDTH'((n_full + 1'b1) >> 1);
    assign lo       = WIDTH'(n_full >> 1);
    assign ld_val   = (mode == 3'd3) ? hi : (mode == 3'd2) ? n2 : cr;
    assign slow     = (mode == 3'd1) || (mode == 3'd5);
    assign trigger  = GATE && !prev_gate;
    assign load     = (null_count && !slow) || trig_q;
    assign en       = running && (slow || GATE);
    assign tc       = (ce == ONE);

    assign count_out = latched ? latch_val : ce;
    assign status    = {OUT, null_count, mode};

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            mode       <= '0;
            cr         <= '0;
            cr_valid   <= 1'b0;
            ce         <= '0;
            OUT        <= 1'b0;
            null_count <= 1'b0;
            latch_val  <= '0;
            latched    <= 1'b0;
            prev_gate  <= 1'b0;
            running    <= 1'b0;
            armed      <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            prev_gate <= GATE;
            if (latched) begin
                if (read_ack)
                    latched <= 1'b0;
            end else if (latch_cmd) begin
                latched   <= 1'b1;
                latch_val <= ce;
            end
            if (cw_wr) begin
                mode       <= cw_alias;
                cr_valid   <= 1'b0;
                null_count <= 1'b0;
                running    <= 1'b0;
                armed      <= 1'b0;
                trig_q     <= 1'b0;
                OUT        <= (cw_alias != 3'd0);
            end else begin
                trig_q <= trigger && cr_valid && (mode != 3'd0) && (mode != 3'd4);
                if (load) begin
                    ce         <= ld_val;
                    null_count <= 1'b0;
                    running    <= 1'b1;
                    armed      <= 1'b1;
                    OUT        <= (mode == 3'd1) ? 1'b0 : (mode == 3'd0) ? OUT : 1'b1;
                end else if (running) begin
                    if (mode == 3'd2 || mode == 3'd3) begin
                        if (!GATE) begin
                            OUT <= 1'b1;
                        end else if (tc) begin
                            OUT <= (mode == 3'd3) ? !OUT : 1'b1;
                            ce  <= (mode == 3'd2) ? n2 : (OUT ? lo : hi);
                        end else begin
                            ce <= ce - ONE;
                            if (mode == 3'd2 && ce == TWO)
                                OUT <= 1'b0;
                        end
                    end else begin
                        if (en)
                            ce <= ce - ONE;
                        if (mode == 3'd0 || mode == 3'd1) begin
                            if (en && tc)
                                OUT <= 1'b1;
                        end else begin
                            // Strobe modes pulse only on the first terminal count after a load.
                            OUT <= !(en && tc && armed);
                            if (en && tc)
                                armed <= 1'b0;
                        end
                    end
                end
                if (count_wr) begin
                    cr         <= count_data;
                    cr_valid   <= 1'b1;
                    null_count <= 1'b1;
                    if (mode == 3'd0)
                        OUT <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_counter_channel.sv
// tb_counter_channel: directed checks of counter_channel modes, latch and reset.
module tb_counter_channel;
    logic        CLK = 1'b0;
    logic        RESET_N, GATE, cw_wr, count_wr, latch_cmd, read_ack;
    logic [2:0]  cw_mode;
    logic [15:0] count_data;
    logic        out16, null16, latched16;
    logic [15:0] count16;
    logic [4:0]  status16;
    logic        out8, null8, latched8;
    logic [7:0]  count8;
    logic [4:0]  status8;
    int          checks = 0;
    int          errors = 0;

    always #5 CLK = ~CLK;

    counter_channel #(.WIDTH(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .GATE(GATE), .cw_wr(cw_wr), .cw_mode(cw_mode),
        .count_wr(count_wr), .count_data(count_data), .latch_cmd(latch_cmd),
        .read_ack(read_ack), .OUT(out16), .null_count(null16), .count_out(count16),
        .latched(latched16), .status(status16)
    );

    counter_channel #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RESET_N(RESET_N), .GATE(GATE), .cw_wr(cw_wr), .cw_mode(cw_mode),
        .count_wr(count_wr), .count_data(count_data[7:0]), .latch_cmd(latch_cmd),
        .read_ack(read_ack), .OUT(out8), .null_count(null8), .count_out(count8),
        .latched(latched8), .status(status8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wr_cw(input logic [2:0] m);
        cw_wr = 1'b1;
        cw_mode = m;
        tick(1);
        cw_wr = 1'b0;
    endtask

    task automatic wr_count(input logic [15:0] n);
        count_wr = 1'b1;
        count_data = n;
        tick(1);
        count_wr = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RESET_N = 1'b0; GATE = 1'b0; cw_wr = 1'b0; cw_mode = 3'd0;
        count_wr = 1'b0; count_data = '0; latch_cmd = 1'b0; read_ack = 1'b0;
        tick(2);
        check("rst_out", out16, 0);
        check("rst_null", null16, 0);
        check("rst_count", count16, 0);
        check("rst_latched", latched16, 0);
        check("rst_status", status16, 0);
        RESET_N = 1'b1;

        // Mode 0, N=5
        GATE = 1'b1;
        wr_cw(3'd0);
        check("m0_cw_out", out16, 0);
        wr_count(16'd5);
        check("m0_e0_null", null16, 1);
        check("m0_e0_out", out16, 0);
        tick(1);
        check("m0_e1_null", null16, 0);
        check("m0_e1_ce", count16, 5);
        tick(4);
        check("m0_e5_out", out16, 0);
        check("m0_e5_ce", count16, 1);
        tick(1);
        check("m0_e6_out", out16, 1);
        tick(1);
        check("m0_wrap_ce", count16, 16'hFFFF);
        check("m0_wrap_out", out16, 1);

        // Mode 0 with GATE low for two cycles
        wr_count(16'd5);
        check("m0g_e0_out", out16, 0);
        tick(2);
        GATE = 1'b0;
        tick(2);
        check("m0g_hold_ce", count16, 4);
        GATE = 1'b1;
        tick(3);
        check("m0g_e7_out", out16, 0);
        tick(1);
        check("m0g_e8_out", out16, 1);

        // Mode 2 (via alias 6), N=4
        wr_cw(3'd6);
        check("m2_mode", status16[2:0], 2);
        check("m2_cw_out", out16, 1);
        wr_count(16'd4);
        tick(4);
        check("m2_e4_out", out16, 0);
        check("m2_e4_ce", count16, 1);
        tick(1);
        check("m2_e5_out", out16, 1);
        check("m2_e5_ce", count16, 4);
        tick(1);
        GATE = 1'b0;
        tick(1);
        check("m2_gl_out", out16, 1);
        check("m2_gl_ce", count16, 3);
        tick(1);
        check("m2_gl_hold", count16, 3);
        GATE = 1'b1;
        tick(2);
        check("m2_rl_ce", count16, 4);
        tick(2);
        check("m2_e12_out", out16, 1);
        tick(1);
        check("m2_e13_out", out16, 0);
        tick(1);
        check("m2_e14_out", out16, 1);
        check("m2_e14_ce", count16, 4);

        // Mode 3 (via alias 7): N=5, then N=4, then N=1
        wr_cw(3'd7);
        check("m3_mode", status16[2:0], 3);
        wr_count(16'd5);
        tick(1);
        check("m3_e1_ce", count16, 3);
        tick(2);
        check("m3_e3_out", out16, 1);
        tick(1);
        check("m3_e4_out", out16, 0);
        check("m3_e4_ce", count16, 2);
        tick(1);
        check("m3_e5_out", out16, 0);
        tick(1);
        check("m3_e6_out", out16, 1);
        check("m3_e6_ce", count16, 3);
        wr_count(16'd4);
        tick(1);
        check("m3n4_ld_ce", count16, 2);
        check("m3n4_null", null16, 0);
        tick(2);
        check("m3n4_lo1", out16, 0);
        tick(1);
        check("m3n4_lo2", out16, 0);
        tick(1);
        check("m3n4_hi", out16, 1);
        wr_count(16'd1);
        tick(1);
        check("m3n1_ld_ce", count16, 1);
        check("m3n1_hi", out16, 1);
        tick(1);
        check("m3n1_lo", out16, 0);
        tick(1);
        check("m3n1_hi2", out16, 1);

        // Reset mid-count overrides strobes in the same cycle
        RESET_N = 1'b0; count_wr = 1'b1; count_data = 16'd9; latch_cmd = 1'b1;
        tick(1);
        RESET_N = 1'b1; count_wr = 1'b0; latch_cmd = 1'b0;
        check("rst2_out", out16, 0);
        check("rst2_null", null16, 0);
        check("rst2_count", count16, 0);
        check("rst2_latched", latched16, 0);
        check("rst2_status", status16, 0);

        // cw_wr + count_wr together: count dropped; trigger without count ignored
        GATE = 1'b0;
        cw_wr = 1'b1; cw_mode = 3'd1; count_wr = 1'b1; count_data = 16'd3;
        tick(1);
        cw_wr = 1'b0; count_wr = 1'b0;
        check("drop_status", status16, 5'b10001);
        GATE = 1'b1;
        tick(1);
        GATE = 1'b0;
        tick(2);
        check("drop_ce", count16, 0);
        check("drop_out", out16, 1);

        // Mode 1, N=3
        wr_count(16'd3);
        check("m1_e0_null", null16, 1);
        tick(1);
        check("m1_wait_ce", count16, 0);
        GATE = 1'b1;
        tick(2);
        check("m1_ld_out", out16, 0);
        check("m1_ld_ce", count16, 3);
        check("m1_ld_null", null16, 0);
        tick(2);
        check("m1_e5_out", out16, 0);
        tick(1);
        check("m1_e6_out", out16, 1);
        GATE = 1'b0;
        tick(1);
        GATE = 1'b1;
        tick(2);
        check("m1_rt_ce", count16, 3);
        GATE = 1'b0;
        tick(1);
        GATE = 1'b1;
        tick(2);
        check("m1_rt2_out", out16, 0);
        check("m1_rt2_ce", count16, 3);
        tick(2);
        check("m1_e14_out", out16, 0);
        tick(1);
        check("m1_e15_out", out16, 1);

        // Mode 5, N=3
        GATE = 1'b0;
        wr_cw(3'd5);
        wr_count(16'd3);
        check("m5_status", status16, 5'b11101);
        tick(1);
        GATE = 1'b1;
        tick(2);
        check("m5_ld_ce", count16, 3);
        check("m5_ld_out", out16, 1);
        GATE = 1'b0;
        tick(1);
        check("m5_nogate_ce", count16, 2);
        tick(1);
        check("m5_e5_out", out16, 1);
        tick(1);
        check("m5_e6_out", out16, 0);
        tick(1);
        check("m5_e7_out", out16, 1);
        GATE = 1'b1;
        tick(2);
        GATE = 1'b0;
        tick(1);
        GATE = 1'b1;
        tick(2);
        check("m5_rt_ce", count16, 3);
        check("m5_rt_out", out16, 1);
        tick(2);
        check("m5_e14_out", out16, 1);
        tick(1);
        check("m5_e15_out", out16, 0);
        tick(1);
        check("m5_e16_out", out16, 1);

        // Mode 4, N=2
        wr_cw(3'd4);
        wr_count(16'd2);
        tick(2);
        check("m4_e2_out", out16, 1);
        tick(1);
        check("m4_e3_out", out16, 0);
        tick(1);
        check("m4_e4_out", out16, 1);
        check("m4_e4_ce", count16, 16'hFFFF);

        // Count latch
        wr_cw(3'd0);
        GATE = 1'b0;
        wr_count(16'h1236);
        tick(1);
        GATE = 1'b1;
        tick(2);
        latch_cmd = 1'b1;
        tick(1);
        latch_cmd = 1'b0;
        check("lat_flag", latched16, 1);
        check("lat_val", count16, 16'h1234);
        tick(3);
        check("lat_hold", count16, 16'h1234);
        latch_cmd = 1'b1;
        tick(1);
        latch_cmd = 1'b0;
        check("lat_ignore", count16, 16'h1234);
        read_ack = 1'b1;
        tick(1);
        read_ack = 1'b0;
        check("lat_rel_flag", latched16, 0);
        check("lat_rel_ce", count16, 16'h122E);
        latch_cmd = 1'b1;
        tick(1);
        check("lat2_val", count16, 16'h122E);
        read_ack = 1'b1;
        tick(1);
        latch_cmd = 1'b0; read_ack = 1'b0;
        check("lat_both_flag", latched16, 0);
        check("lat_both_ce", count16, 16'h122C);

        // WIDTH=8, N=0 counts 256 cycles
        wr_cw(3'd0);
        wr_count(16'h0000);
        tick(1);
        check("w8_ld_ce", count8, 0);
        tick(255);
        check("w8_e256_out", out8, 0);
        check("w8_e256_ce", count8, 8'h01);
        tick(1);
        check("w8_e257_out", out8, 1);
        check("w8_e257_ce", count8, 8'h00);
        check("w8_null", null8, 0);
        check("w8_latched", latched8, 0);
        check("w8_status", status8, 5'b10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
